// File: rtl/gb_cart_pkg.sv
// Shared constants, types and region decode for the Game Boy cartridge mappers.
package gb_cart_pkg;

    localparam logic [15:0] ROM0_BASE  = 16'h0000;
    localparam logic [15:0] ROMX_BASE  = 16'h4000;
    localparam logic [15:0] RAM_BASE   = 16'hA000;

    localparam logic [15:0] REG_RAMEN  = 16'h0000;
    localparam logic [15:0] REG_BANKLO = 16'h2000;
    localparam logic [15:0] REG_BANKHI = 16'h4000;
    localparam logic [15:0] REG_MODE   = 16'h6000;

    localparam logic [3:0] RAM_KEY     = 4'hA;
    localparam logic [7:0] CART_DO_RST = 8'hFF;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {RG_ROM0, RG_ROMX, RG_RAM, RG_NONE} region_t;

    function automatic region_t region_of(input logic [15:0] a);
        if (a[15:14] == ROM0_BASE[15:14])
            return RG_ROM0;
        else if (a[15:14] == ROMX_BASE[15:14])
            return RG_ROMX;
        else if (a[15:13] == RAM_BASE[15:13])
            return RG_RAM;
        else
            return RG_NONE;
    endfunction

endpackage

// File: rtl/mbc1_bank_map.sv
// Combinational MBC1 address translation: 16-bit bus address to flat ROM/RAM byte address.
module mbc1_bank_map
    import gb_cart_pkg::*;
#(
    parameter int ROM_AW = 21,
    parameter int RAM_AW = 15
) (
    input  logic [15:0]       addr,
    input  logic [4:0]        bank_lo,
    input  logic [1:0]        bank_hi,
    input  logic              mode,
    input  logic [6:0]        rom_mask,
    input  logic              ram_en,
    input  logic              ram_present,
    output logic [ROM_AW-1:0] map_addr,
    output logic              sel_ram,
    output logic              rom_hit,
    output logic              ram_hit,
    output logic              ram_ok
);

    region_t    rg;
    logic [6:0] bank_raw;
    logic [6:0] bank;
    logic [1:0] rbank;

    always_comb begin
        rg       = region_of(addr);
        // In mode 1 the upper bank bits also steer the fixed 0000-3FFF window.
        if (rg == RG_ROMX)
            bank_raw = {bank_hi, bank_lo};
        else
            bank_raw = mode ? {bank_hi, 5'b0} : 7'd0;
        bank     = bank_raw & rom_mask;
        rbank    = mode ? bank_hi : 2'b00;
        rom_hit  = (rg == RG_ROM0) || (rg == RG_ROMX);
        ram_hit  = (rg == RG_RAM);
        ram_ok   = ram_hit && ram_en && ram_present;
        sel_ram  = ram_hit;
        if (ram_hit)
            map_addr = ROM_AW'(RAM_AW'({rbank, addr[12:0]}));
        else
            map_addr = ROM_AW'({bank, addr[13:0]});
    end

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 mapper: control registers, strobe edge detect, one-deep pending slot and memory handshake FSM.
// state | meaning
// IDLE  | no access outstanding; launches a bus or pending access
// REQ   | mem_req held with stable fields until mem_ack
// DONE  | access finished, cart_do valid, back to IDLE
module cart_mbc1
    import gb_cart_pkg::*;
#(
    parameter int ROM_AW = 21,
    parameter int RAM_AW = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cart_addr,
    input  logic              cart_rd,
    input  logic              cart_wr,
    input  logic [7:0]        cart_di,
    output logic [7:0]        cart_do,
    output logic              cart_ready,
    input  logic [6:0]        rom_mask,
    input  logic              ram_present,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic              mem_sel_ram,
    output logic [ROM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic        ram_en, mode;
    logic [4:0]  bank_lo;
    logic [1:0]  bank_hi;
    logic        rd_q, wr_q;
    logic [15:0] addr_q;
    state_t      state, state_nx;
    logic        pend, pend_we;
    logic [15:0] pend_addr;
    logic [7:0]  pend_data;

    logic        rd_edge, wr_edge, addr_move, rd_ev, ctrl_wr, bus_ev, use_pend;
    logic        launch, ff_load, launch_we;
    logic [7:0]  launch_data;
    logic [15:0] map_in;
    region_t     bus_rg;

    logic [ROM_AW-1:0] map_addr;
    logic              map_sel_ram, map_rom_hit, map_ram_hit, map_ram_ok;

    always_comb begin
        rd_edge     = cart_rd & ~rd_q;
        wr_edge     = cart_wr & ~wr_q;
        bus_rg      = region_of(cart_addr);
        ctrl_wr     = wr_edge & ~cart_addr[15];
        // A moving address under a held read only counts as a new access while busy.
        addr_move   = cart_rd & rd_q & ~wr_edge & (cart_addr != addr_q);
        rd_ev       = (rd_edge & ~wr_edge) | (addr_move & (state != IDLE));
        bus_ev      = (rd_ev & (bus_rg != RG_NONE)) | (wr_edge & (bus_rg == RG_RAM));
        use_pend    = (state == IDLE) & pend & ~bus_ev;
        map_in      = use_pend ? pend_addr : cart_addr;
        launch_we   = use_pend ? pend_we : wr_edge;
        launch_data = use_pend ? pend_data : cart_di;
    end

    mbc1_bank_map #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) u_map (
        .addr        (map_in),
        .bank_lo     (bank_lo),
        .bank_hi     (bank_hi),
        .mode        (mode),
        .rom_mask    (rom_mask),
        .ram_en      (ram_en),
        .ram_present (ram_present),
        .map_addr    (map_addr),
        .sel_ram     (map_sel_ram),
        .rom_hit     (map_rom_hit),
        .ram_hit     (map_ram_hit),
        .ram_ok      (map_ram_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        ff_load  = 1'b0;
        case (state)
            IDLE: begin
                if (bus_ev || pend) begin
                    if (map_ram_hit && !map_ram_ok) begin
                        ff_load = ~launch_we;
                    end else if (map_rom_hit || map_ram_ok) begin
                        launch   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ:     if (mem_ack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req    = (state == REQ);
    assign cart_ready = (state != REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en      <= 1'b0;
            bank_lo     <= 5'd1;
            bank_hi     <= 2'd0;
            mode        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 16'h0000;
            pend        <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= 16'h0000;
            pend_data   <= 8'h00;
            cart_do     <= CART_DO_RST;
            mem_we      <= 1'b0;
            mem_sel_ram <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
        end else begin
            rd_q   <= cart_rd;
            wr_q   <= cart_wr;
            addr_q <= cart_addr;

            if (ctrl_wr) begin
                if (cart_addr[14:13] == REG_RAMEN[14:13])
                    ram_en <= (cart_di[3:0] == RAM_KEY);
                if (cart_addr[14:13] == REG_BANKLO[14:13])
                    bank_lo <= (cart_di[4:0] == 5'd0) ? 5'd1 : cart_di[4:0];
                if (cart_addr[14:13] == REG_BANKHI[14:13])
                    bank_hi <= cart_di[1:0];
                if (cart_addr[14:13] == REG_MODE[14:13])
                    mode <= cart_di[0];
            end

            if (state == IDLE && (bus_ev || pend)) begin
                pend <= 1'b0;
            end else if (state != IDLE && bus_ev) begin
                pend      <= 1'b1;
                pend_addr <= cart_addr;
                pend_we   <= wr_edge;
                pend_data <= cart_di;
            end

            if (launch) begin
                mem_addr    <= map_addr;
                mem_sel_ram <= map_sel_ram;
                mem_we      <= launch_we;
                mem_wdata   <= launch_data;
            end

            if (ff_load)
                cart_do <= CART_DO_RST;
            else if (state == REQ && mem_ack && !mem_we)
                cart_do <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cart_mbc1.sv
// Self-checking bench for cart_mbc1: directed scenarios plus randomized accesses against a bank-arithmetic model.
module tb_cart_mbc1;

    localparam int ROM_AW = 21;
    localparam int RAM_AW = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [15:0]       cart_addr = 16'h0000;
    logic              cart_rd = 1'b0;
    logic              cart_wr = 1'b0;
    logic [7:0]        cart_di = 8'h00;
    logic [7:0]        cart_do;
    logic              cart_ready;
    logic [6:0]        rom_mask = 7'h7F;
    logic              ram_present = 1'b1;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic              mem_we;
    logic              mem_sel_ram;
    logic [ROM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;

    cart_mbc1 #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cart_addr   (cart_addr),
        .cart_rd     (cart_rd),
        .cart_wr     (cart_wr),
        .cart_di     (cart_di),
        .cart_do     (cart_do),
        .cart_ready  (cart_ready),
        .rom_mask    (rom_mask),
        .ram_present (ram_present),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_we      (mem_we),
        .mem_sel_ram (mem_sel_ram),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         m_ram_en, m_lo, m_hi, m_mode;
    logic [7:0] m_do;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ram_en = 0; m_lo = 1; m_hi = 0; m_mode = 0; m_do = 8'hFF;
    endtask

    task automatic model_ctrl(input int a, input int d);
        case (a / 8192)
            0: m_ram_en = ((d % 16) == 10) ? 1 : 0;
            1: begin m_lo = d % 32; if (m_lo == 0) m_lo = 1; end
            2: m_hi = d % 4;
            default: m_mode = d % 2;
        endcase
    endtask

    function automatic int exp_rom(input int a);
        int bank;
        if (a < 16384) bank = (m_mode != 0) ? m_hi * 32 : 0;
        else           bank = m_hi * 32 + m_lo;
        bank = bank & int'(rom_mask);
        return bank * 16384 + (a % 16384);
    endfunction

    function automatic int exp_ram(input int a);
        return ((m_mode != 0) ? m_hi : 0) * 8192 + (a % 8192);
    endfunction

    task automatic bus_op(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d);
        @(negedge clk);
        cart_addr = a; cart_di = d; cart_rd = rd; cart_wr = wr;
        @(negedge clk);
        cart_rd = 1'b0; cart_wr = 1'b0;
    endtask

    task automatic serve(input string tag, input int exp_addr, input logic exp_ram, input logic exp_we,
                         input logic [7:0] exp_wd, input int dly, input logic [7:0] rdata);
        int t = 0;
        int low = 0;
        while (!mem_req && t < 8) begin @(negedge clk); t++; end
        chk({tag, "_req"}, mem_req, 1);
        if (!mem_req) return;
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_selram"}, mem_sel_ram, exp_ram);
        chk({tag, "_we"}, mem_we, exp_we);
        if (exp_we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        for (int i = 0; i < dly; i++) begin
            if (!cart_ready) low++;
            @(negedge clk);
        end
        if (!cart_ready) low++;
        chk({tag, "_hold"}, mem_addr, exp_addr);
        mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'($urandom);
        chk({tag, "_lowcyc"}, low, dly + 1);
        chk({tag, "_ready"}, cart_ready, 1);
        chk({tag, "_reqdrop"}, mem_req, 0);
        if (!exp_we) m_do = rdata;
        chk({tag, "_do"}, cart_do, m_do);
    endtask

    task automatic quiet(input string tag);
        logic seen = 1'b0;
        logic busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) seen = 1'b1;
            if (!cart_ready) busy = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_noreq"}, seen, 0);
        chk({tag, "_rdy"}, busy, 0);
        chk({tag, "_do"}, cart_do, m_do);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] masks [4];
        masks[0] = 7'h7F; masks[1] = 7'h3F; masks[2] = 7'h1F; masks[3] = 7'h0F;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_do", cart_do, 8'hFF);
        chk("rst_ready", cart_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_selram", mem_sel_ram, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset_n = 1'b1;

        bus_op(16'h0150, 1, 0, 0);
        serve("rd0150", 'h00150, 0, 0, 0, 3, 8'h3C);

        bus_op(16'h2000, 0, 1, 8'h00); model_ctrl('h2000, 'h00);
        quiet("ctl_lo0");
        bus_op(16'h4000, 1, 0, 0);
        serve("rd4000", 'h04000, 0, 0, 0, 2, 8'hA1);
        bus_op(16'h2000, 0, 1, 8'h25); model_ctrl('h2000, 'h25);
        bus_op(16'h7FFF, 1, 0, 0);
        serve("rd7fff", 'h17FFF, 0, 0, 0, 1, 8'hB2);

        bus_op(16'h4000, 0, 1, 8'h02); model_ctrl('h4000, 2);
        bus_op(16'h6000, 0, 1, 8'h01); model_ctrl('h6000, 1);
        rom_mask = 7'h3F;
        bus_op(16'h0000, 1, 0, 0);
        serve("mode1_m3f", 'h00000, 0, 0, 0, 2, 8'hC3);
        rom_mask = 7'h7F;
        bus_op(16'h0000, 1, 0, 0);
        serve("mode1_m7f", 'h100000, 0, 0, 0, 2, 8'hD4);

        bus_op(16'hA000, 1, 0, 0); m_do = 8'hFF;
        quiet("ram_gated");
        bus_op(16'h0000, 0, 1, 8'h0A); model_ctrl('h0000, 'h0A);
        bus_op(16'h4000, 0, 1, 8'h03); model_ctrl('h4000, 3);
        bus_op(16'hA123, 0, 1, 8'h5A);
        serve("ramwr", 'h6123, 1, 1, 8'h5A, 2, 8'h00);

        bus_op(16'h0100, 1, 0, 0);
        chk("ovl_first_addr", mem_addr, exp_rom('h0100));
        bus_op(16'h0200, 1, 0, 0);
        chk("ovl_busy", cart_ready, 0);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge clk);
        mem_ack = 1'b0; m_do = 8'h11;
        chk("ovl_done_req", mem_req, 0);
        chk("ovl_done_do", cart_do, 8'h11);
        serve("ovl_pend", exp_rom('h0200), 0, 0, 0, 2, 8'h22);

        @(negedge clk);
        cart_addr = 16'h6000; cart_di = 8'h00; cart_rd = 1'b1; cart_wr = 1'b1;
        @(negedge clk);
        cart_rd = 1'b0; cart_wr = 1'b0; model_ctrl('h6000, 0);
        quiet("rdwr");
        bus_op(16'h0000, 1, 0, 0);
        serve("rdwr_mode0", 'h00000, 0, 0, 0, 1, 8'h33);

        bus_op(16'h0150, 1, 0, 0);
        chk("rstmid_req_pre", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_ready", cart_ready, 1);
        @(negedge clk);
        reset_n = 1'b1; model_reset();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_do", cart_do, 8'hFF);
        quiet("late_ack");

        for (int n = 0; n < 150; n++) begin
            int op, a, d;
            rom_mask    = masks[$urandom_range(0, 3)];
            ram_present = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 5);
            d  = $urandom_range(0, 255);
            case (op)
                0: begin
                    a = $urandom_range(0, 'h7FFF);
                    if (a < 'h2000 && $urandom_range(0, 1) == 1) d = (d & 'hF0) | 'hA;
                    bus_op(16'(a), 0, 1, 8'(d)); model_ctrl(a, d);
                    quiet("r_ctl");
                end
                1, 2: begin
                    a = $urandom_range(0, 'h7FFF);
                    bus_op(16'(a), 1, 0, 0);
                    serve("r_rom", exp_rom(a), 0, 0, 0, $urandom_range(1, 4), 8'(d));
                end
                3, 4: begin
                    a = $urandom_range('hA000, 'hBFFF);
                    bus_op(16'(a), (op == 3), (op == 4), 8'(d));
                    if (m_ram_en != 0 && ram_present)
                        serve("r_ram", exp_ram(a), 1, (op == 4), 8'(d), $urandom_range(1, 4), 8'($urandom));
                    else begin
                        if (op == 3) m_do = 8'hFF;
                        quiet("r_ramoff");
                    end
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? $urandom_range('h8000, 'h9FFF)
                                                     : $urandom_range('hC000, 'hFFFF);
                    bus_op(16'(a), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 8'(d));
                    quiet("r_ign");
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
